// File: rtl/p405s_storage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p405s_storage_pkg
// Description : Shared types and helpers for the storage sequencer: FSM
//               state encoding, legal data-side beat widths and the
//               byte-enable mask builder.
// Revision    : 1.0 - initial release
// ============================================================================
package p405s_storage_pkg;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Legal data-side beat widths in bytes
  localparam int c_BB_4   = 4;
  localparam int c_BB_8   = 8;
  localparam int c_BB_16  = 16;
  localparam int c_BB_MAX = c_BB_16;

  // True when the beat width is one the sequencer supports
  function automatic bit bus_legal(input int bytes);
    return (bytes == c_BB_4) || (bytes == c_BB_8) || (bytes == c_BB_16);
  endfunction

  // Contiguous run of n enables starting at byte lane off (bit 0 = lowest
  // address). n = 0 gives an empty mask; n = 16 with off = 0 gives all ones.
  function automatic logic [c_BB_MAX-1:0] be_mask(input logic [4:0] off,
                                                   input logic [4:0] n);
    logic [c_BB_MAX-1:0] ones;
    ones = {c_BB_MAX{1'b1}} >> (5'd16 - n);
    return ones << off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p405s_storage_beatCalc.sv
`default_nettype none
// ============================================================================
// Module      : p405s_storage_beatCalc
// Description : Per-beat decode: number of bytes moved this beat, the
//               byte-enable lanes and the last-beat flag, computed from the
//               remaining byte count and the current in-beat offset.
// Revision    : 1.0 - initial release
// ============================================================================
module p405s_storage_beatCalc
  import p405s_storage_pkg::*;
#(
  parameter int BUS_BYTES = 4,
  parameter int CNT_W     = 8,
  parameter int OFF_W     = $clog2(BUS_BYTES)
) (
  input  logic [CNT_W-1:0]     i_rem,
  input  logic [OFF_W-1:0]     i_off,
  output logic [OFF_W:0]       o_n,
  output logic [BUS_BYTES-1:0] o_byteEn,
  output logic                 o_last
);

  // Bytes left in the line from the current offset to its end
  logic [OFF_W:0] w_space;

  // n = min(rem, space); the beat covers lanes off .. off+n-1
  always_comb begin
    w_space  = (OFF_W+1)'(BUS_BYTES) - {1'b0, i_off};
    o_n      = (i_rem < CNT_W'(w_space)) ? i_rem[OFF_W:0] : w_space;
    o_byteEn = BUS_BYTES'(be_mask(5'(i_off), 5'(o_n)));
    o_last   = (i_rem == CNT_W'(o_n));
  end

endmodule
`default_nettype wire

// File: rtl/p405s_storage_seq.sv
`default_nettype none
// ============================================================================
// Module      : p405s_storage_seq
// Description : Storage-access sequencer. Accepts a byte-count/offset
//               request, splits it into line-bounded beats toward the data
//               side with a valid/ack handshake, and reports completion,
//               misalignment rejection or flush abort.
// Revision    : 1.0 - initial release
// ============================================================================
module p405s_storage_seq
  import p405s_storage_pkg::*;
#(
  parameter int BUS_BYTES = 4,
  parameter int CNT_W     = 8,
  parameter int OFF_W     = $clog2(BUS_BYTES)
) (
  input  logic                 CB,
  input  logic                 reset,
  input  logic                 startVal,
  output logic                 startRdy,
  input  logic [CNT_W-1:0]     startCnt,
  input  logic [OFF_W-1:0]     startEa,
  input  logic                 startStr,
  input  logic                 startForceAlgn,
  output logic                 dsReq,
  input  logic                 dsAck,
  output logic [BUS_BYTES-1:0] dsByteEn,
  output logic [OFF_W-1:0]     dsOff,
  output logic                 dsLast,
  output logic [CNT_W-1:0]     remCnt,
  input  logic                 flush,
  output logic                 done,
  output logic                 algnErr
);

  if (!bus_legal(BUS_BYTES)) begin : g_badBus
    $error("p405s_storage_seq: BUS_BYTES must be 4, 8 or 16");
  end

  state_e               r_state;
  state_e               w_nextState;
  logic [CNT_W-1:0]     r_rem;
  logic [OFF_W-1:0]     r_off;
  logic                 r_algnErr;

  logic [OFF_W:0]       w_n;
  logic [BUS_BYTES-1:0] w_beatEn;
  logic                 w_beatLast;
  logic [CNT_W-1:0]     w_algnSize;
  logic                 w_accept;
  logic                 w_misalign;
  logic                 w_nop;
  logic                 w_ack;

  p405s_storage_beatCalc #(
    .BUS_BYTES (BUS_BYTES),
    .CNT_W     (CNT_W),
    .OFF_W     (OFF_W)
  ) u_beatCalc (
    .i_rem    (r_rem),
    .i_off    (r_off),
    .o_n      (w_n),
    .o_byteEn (w_beatEn),
    .o_last   (w_beatLast)
  );

  // Request qualification; a flush in IDLE swallows the same-cycle request.
  // The alignment unit is min(count, bus width); a zero count never
  // misaligns, so the divisor is forced to 1 to keep the remainder defined.
  always_comb begin
    w_accept   = startVal && (r_state == ST_IDLE) && !flush;
    w_nop      = (startCnt == '0);
    if (w_nop) begin
      w_algnSize = CNT_W'(1);
    end else if (startCnt < CNT_W'(BUS_BYTES)) begin
      w_algnSize = startCnt;
    end else begin
      w_algnSize = CNT_W'(BUS_BYTES);
    end
    w_misalign = !startStr && startForceAlgn && !w_nop &&
                 ((CNT_W'(startEa) % w_algnSize) != '0);
    w_ack      = (r_state == ST_XFER) && dsAck;
  end

  // State register
  always_ff @(posedge CB) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; flush wins over a simultaneous ack
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_misalign) begin
          w_nextState = w_nop ? ST_DONE : ST_XFER;
        end
      end
      ST_XFER: begin
        if (flush) begin
          w_nextState = ST_IDLE;
        end else if (w_ack && w_beatLast) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Remaining count, in-line offset and the misalignment pulse register.
  // The offset returns to 0 once a transfer ends so it only carries a
  // non-zero value while beats are outstanding.
  always_ff @(posedge CB) begin
    if (reset) begin
      r_rem     <= '0;
      r_off     <= '0;
      r_algnErr <= 1'b0;
    end else begin
      r_algnErr <= w_accept && w_misalign;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_misalign && !w_nop) begin
            r_rem <= startCnt;
            r_off <= startEa;
          end
        end
        ST_XFER: begin
          if (flush) begin
            r_rem <= '0;
            r_off <= '0;
          end else if (w_ack) begin
            r_rem <= r_rem - CNT_W'(w_n);
            // n never exceeds the line space, so the OFF_W-bit sum wraps
            // to 0 exactly at the line end
            r_off <= w_beatLast ? '0 : (r_off + w_n[OFF_W-1:0]);
          end
        end
        ST_DONE: begin
          r_rem <= '0;
          r_off <= '0;
        end
        default: begin
          r_rem <= '0;
          r_off <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    startRdy = (r_state == ST_IDLE);
    dsReq    = (r_state == ST_XFER);
    dsByteEn = dsReq ? w_beatEn : '0;
    dsLast   = dsReq && w_beatLast;
    dsOff    = r_off;
    remCnt   = r_rem;
    done     = (r_state == ST_DONE);
    algnErr  = r_algnErr;
  end

endmodule
`default_nettype wire

// File: tb/tb_p405s_storage_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_p405s_storage_seq
// Description : Self-checking bench. Three sequencer instances (4, 8 and
//               16-byte beats) share most inputs; each request is driven to
//               one instance and compared beat by beat against a byte-address
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p405s_storage_seq;

  logic       CB = 1'b0;
  logic       reset;
  logic [2:0] sv;
  logic [7:0] startCnt;
  logic [3:0] startEa;
  logic       startStr;
  logic       startForceAlgn;
  logic       dsAck;
  logic       flush;

  logic        rdy_all  [3];
  logic        req_all  [3];
  logic        last_all [3];
  logic        done_all [3];
  logic        aerr_all [3];
  logic [15:0] en_all   [3];
  logic [3:0]  offo_all [3];
  logic [7:0]  rem_all  [3];

  int checks = 0;
  int errors = 0;

  always #5 CB = ~CB;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int BB = 4 << k;
    localparam int OW = 2 + k;
    logic [BB-1:0] w_en;
    logic [OW-1:0] w_off;
    logic          w_rdy, w_req, w_last, w_done, w_aerr;
    logic [7:0]    w_rem;

    p405s_storage_seq #(.BUS_BYTES(BB), .CNT_W(8)) u_dut (
      .CB             (CB),
      .reset          (reset),
      .startVal       (sv[k]),
      .startRdy       (w_rdy),
      .startCnt       (startCnt),
      .startEa        (startEa[OW-1:0]),
      .startStr       (startStr),
      .startForceAlgn (startForceAlgn),
      .dsReq          (w_req),
      .dsAck          (dsAck),
      .dsByteEn       (w_en),
      .dsOff          (w_off),
      .dsLast         (w_last),
      .remCnt         (w_rem),
      .flush          (flush),
      .done           (w_done),
      .algnErr        (w_aerr)
    );

    assign rdy_all[k]  = w_rdy;
    assign req_all[k]  = w_req;
    assign last_all[k] = w_last;
    assign done_all[k] = w_done;
    assign aerr_all[k] = w_aerr;
    assign en_all[k]   = 16'(w_en);
    assign offo_all[k] = 4'(w_off);
    assign rem_all[k]  = w_rem;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CB);
  endtask

  task automatic chk_reset(input int s, input string tag);
    chk({tag, "_rdy"},  32'(rdy_all[s]),  32'd1);
    chk({tag, "_req"},  32'(req_all[s]),  32'd0);
    chk({tag, "_en"},   32'(en_all[s]),   32'd0);
    chk({tag, "_off"},  32'(offo_all[s]), 32'd0);
    chk({tag, "_last"}, 32'(last_all[s]), 32'd0);
    chk({tag, "_rem"},  32'(rem_all[s]),  32'd0);
    chk({tag, "_done"}, 32'(done_all[s]), 32'd0);
    chk({tag, "_aerr"}, 32'(aerr_all[s]), 32'd0);
  endtask

  // One request on instance s. The model walks byte addresses: each beat
  // moves min(remaining, bytes to line end) bytes starting at addr % bb.
  // abortKind 1 = flush, 2 = reset, applied together with the ack of beat
  // number abortBeat (1-based); 0 disables the abort.
  task automatic run_req(input int s, input int cnt, input int ea, input bit str,
                         input bit fa, input int ackPct, input int stallFirst,
                         input int abortBeat, input int abortKind);
    int bb, size, rem, addr, n, o, beat, stalls;
    logic [15:0] m;
    bit ack;
    bb = 4 << s;
    chk("pre_rdy", 32'(rdy_all[s]), 32'd1);
    sv[s] = 1'b1; startCnt = 8'(cnt); startEa = 4'(ea);
    startStr = str; startForceAlgn = fa; dsAck = 1'b0; flush = 1'b0;
    tick();
    sv = '0;
    size = (cnt < bb) ? cnt : bb;
    if (!str && fa && cnt != 0 && (ea % size) != 0) begin
      chk("algn_pulse", 32'(aerr_all[s]), 32'd1);
      chk("algn_req",   32'(req_all[s]),  32'd0);
      chk("algn_rdy",   32'(rdy_all[s]),  32'd1);
      chk("algn_done",  32'(done_all[s]), 32'd0);
      tick();
      chk("algn_clear", 32'(aerr_all[s]), 32'd0);
      chk("algn_rdy2",  32'(rdy_all[s]),  32'd1);
      chk("algn_req2",  32'(req_all[s]),  32'd0);
      return;
    end
    if (cnt == 0) begin
      chk("nop_done", 32'(done_all[s]), 32'd1);
      chk("nop_req",  32'(req_all[s]),  32'd0);
      chk("nop_aerr", 32'(aerr_all[s]), 32'd0);
      tick();
      chk("nop_done2", 32'(done_all[s]), 32'd0);
      chk("nop_rdy",   32'(rdy_all[s]),  32'd1);
      return;
    end
    rem = cnt; addr = ea; beat = 0;
    while (rem > 0) begin
      o = addr % bb;
      n = (rem < bb - o) ? rem : bb - o;
      m = 16'(((1 << n) - 1) << o);
      stalls = 0;
      ack = 1'b0;
      for (int w = 0; w < 64; w++) begin
        chk("beat_req",  32'(req_all[s]),  32'd1);
        chk("beat_en",   32'(en_all[s]),   32'(m));
        chk("beat_off",  32'(offo_all[s]), 32'(o));
        chk("beat_last", 32'(last_all[s]), 32'(rem == n));
        chk("beat_rem",  32'(rem_all[s]),  32'(rem));
        chk("beat_done", 32'(done_all[s]), 32'd0);
        chk("beat_rdy",  32'(rdy_all[s]),  32'd0);
        if (beat == 0 && stalls < stallFirst) ack = 1'b0;
        else if (stalls >= 16) ack = 1'b1;
        else ack = ($urandom_range(99) < 32'(ackPct));
        if (ack) break;
        dsAck = 1'b0;
        stalls++;
        tick();
      end
      dsAck = 1'b1;
      if (abortKind != 0 && beat == abortBeat - 1) begin
        if (abortKind == 1) begin
          flush = 1'b1;
          tick();
          flush = 1'b0; dsAck = 1'b0;
          chk("flush_rdy",  32'(rdy_all[s]),  32'd1);
          chk("flush_req",  32'(req_all[s]),  32'd0);
          chk("flush_rem",  32'(rem_all[s]),  32'd0);
          chk("flush_done", 32'(done_all[s]), 32'd0);
          tick();
          chk("flush_done2", 32'(done_all[s]), 32'd0);
          chk("flush_rdy2",  32'(rdy_all[s]),  32'd1);
        end else begin
          reset = 1'b1;
          tick();
          reset = 1'b0; dsAck = 1'b0;
          chk_reset(s, "midrst");
        end
        return;
      end
      tick();
      dsAck = 1'b0;
      rem -= n; addr += n; beat++;
    end
    chk("end_done", 32'(done_all[s]), 32'd1);
    chk("end_req",  32'(req_all[s]),  32'd0);
    chk("end_rem",  32'(rem_all[s]),  32'd0);
    chk("end_rdy",  32'(rdy_all[s]),  32'd0);
    tick();
    chk("end_done2", 32'(done_all[s]), 32'd0);
    chk("end_rdy2",  32'(rdy_all[s]),  32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, cnt, ea, kind, ab;
    reset = 1'b1; sv = '0; startCnt = '0; startEa = '0; startStr = 1'b0;
    startForceAlgn = 1'b0; dsAck = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) chk_reset(k, "reset");

    // 7 bytes from offset 1 on a 4-byte bus, ack held high
    run_req(0, 7, 1, 1'b1, 1'b0, 100, 0, 0, 0);
    // 16 aligned bytes on an 8-byte bus, first beat stalled 3 cycles
    run_req(1, 16, 0, 1'b1, 1'b0, 100, 3, 0, 0);
    // single-operand misaligned with forced alignment
    run_req(0, 4, 2, 1'b0, 1'b1, 100, 0, 0, 0);
    // aligned single-operand accesses with forced alignment
    run_req(1, 8, 0, 1'b0, 1'b1, 100, 0, 0, 0);
    run_req(2, 4, 4, 1'b0, 1'b1, 100, 0, 0, 0);
    run_req(0, 3, 3, 1'b0, 1'b1, 100, 0, 0, 0);
    // string no-op
    run_req(0, 0, 0, 1'b1, 1'b0, 100, 0, 0, 0);
    // flush together with the ack of beat 3, then a normal request
    run_req(0, 20, 0, 1'b1, 1'b0, 100, 0, 3, 1);
    run_req(0, 20, 0, 1'b1, 1'b0, 100, 0, 0, 0);

    // flush in IDLE drops the same-cycle request
    sv[0] = 1'b1; startCnt = 8'd5; startEa = 4'd0; startStr = 1'b1; flush = 1'b1;
    tick();
    sv = '0; flush = 1'b0;
    chk("idleflush_rdy",  32'(rdy_all[0]),  32'd1);
    chk("idleflush_req",  32'(req_all[0]),  32'd0);
    chk("idleflush_rem",  32'(rem_all[0]),  32'd0);
    tick();
    chk("idleflush_done", 32'(done_all[0]), 32'd0);

    // ack with no beat outstanding is ignored
    dsAck = 1'b1;
    tick();
    dsAck = 1'b0;
    chk_reset(0, "strayack");

    // reset in the middle of a transfer on every bus width
    for (int k = 0; k < 3; k++) run_req(k, 40, 1, 1'b1, 1'b0, 100, 0, 2, 2);

    // randomized requests against the model
    for (int i = 0; i < 60; i++) begin
      s   = $urandom_range(2);
      cnt = ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(40);
      if ($urandom_range(9) == 0) cnt = 0;
      ea  = $urandom_range((4 << s) - 1);
      kind = ($urandom_range(7) == 0) ? 1 : 0;
      ab   = $urandom_range(3, 1);
      run_req(s, cnt, ea, 1'($urandom_range(1)), 1'($urandom_range(1)),
              $urandom_range(100, 30), $urandom_range(2), ab, kind);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
